// File: rtl/resta_pkg.sv
// rtl/resta_pkg.sv - shared state encoding and 7-segment helpers for the resta display
//
// Contents:
//   state_t     FSM state encoding (IDLE, CONV, SHOW)
//   SEG_BLANK   all segments off (active-low)
//   SEG_MINUS   only segment g lit
//   bcd_to_seg  4-bit BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes blank
package resta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD digit to active-low 7-segment pattern
//
// Ports:
//   digit  in   4  BCD digit
//   seg    out  7  active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
  import resta_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/resta_display.sv
// rtl/resta_display.sv - signed subtractor result to sign/BCD on a scanned 4-digit 7-segment display
//
// Parameters:
//   WIDTH     width of the two's-complement input (4..9)
//   SCAN_DIV  clk cycles per digit slot (>= 2)
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   init    in   1      load strobe, honoured in IDLE/SHOW
//   sal_in  in   WIDTH  two's-complement value
//   sseg    out  7      active-low segments {g,f,e,d,c,b,a}
//   an      out  4      active-low digit enables: [0] units, [1] tens, [2] hundreds, [3] sign
//   busy    out  1      high while converting
//   done    out  1      one-cycle pulse when new digits are committed
// Build option:
//   RESTA_DISPLAY_ZERO_BLANK_EN  blank leading zeros in hundreds and tens
module resta_display
  import resta_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] sal_in,
  output logic [6:0]       sseg,
  output logic [3:0]       an,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  state_t state, state_nxt;
  logic   load, shift, commit;

  logic [WIDTH-1:0] mag;
  logic             sign_r;
  logic [11:0]      bcd, bcd_adj, bcd_shift;
  logic [CNT_W-1:0] bit_cnt;

  logic [11:0]       disp_bcd;
  logic              disp_sign;
  logic              valid;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_idx;

  logic [3:0] dec_digit;
  logic [6:0] dec_seg, seg_sel;
  logic       blank_h, blank_t;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The final shift and the commit share one edge; the display registers
  // take the post-shift value directly so no extra cycle is spent in CONV.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE, ST_SHOW: begin
        if (init) begin
          state_nxt = ST_CONV;
          load      = 1'b1;
        end
      end
      ST_CONV: begin
        shift = 1'b1;
        if (bit_cnt == CNT_W'(1)) begin
          state_nxt = ST_SHOW;
          commit    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CONV);

  // ---------------- double dabble ----------------
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_shift = {bcd_adj[10:0], mag[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r    <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= commit;
      if (load) begin
        sign_r  <= sal_in[WIDTH-1];
        // Most-negative input wraps to 2^(WIDTH-1), which is still correct unsigned.
        mag     <= sal_in[WIDTH-1] ? (~sal_in) + {{(WIDTH-1){1'b0}}, 1'b1} : sal_in;
        bcd     <= '0;
        bit_cnt <= CNT_W'(WIDTH);
      end else if (shift) begin
        bcd     <= bcd_shift;
        mag     <= {mag[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt - CNT_W'(1);
      end
      if (commit) begin
        disp_bcd  <= bcd_shift;
        disp_sign <= sign_r;
        valid     <= 1'b1;
      end
    end
  end

  // ---------------- scan ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

`ifdef RESTA_DISPLAY_ZERO_BLANK_EN
  assign blank_h = (disp_bcd[11:8] == 4'd0);
  assign blank_t = (disp_bcd[11:8] == 4'd0) && (disp_bcd[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    dec_digit = disp_bcd[3:0];
    case (dig_idx)
      2'd1:    dec_digit = disp_bcd[7:4];
      2'd2:    dec_digit = disp_bcd[11:8];
      default: dec_digit = disp_bcd[3:0];
    endcase
  end

  seg7_decoder u_dec (
    .digit (dec_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_sel = SEG_BLANK;
    case (dig_idx)
      2'd0: seg_sel = dec_seg;
      2'd1: seg_sel = blank_t ? SEG_BLANK : dec_seg;
      2'd2: seg_sel = blank_h ? SEG_BLANK : dec_seg;
      2'd3: seg_sel = (disp_sign && (disp_bcd != 12'd0)) ? SEG_MINUS : SEG_BLANK;
      default: seg_sel = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !valid) begin
      an   <= 4'b1111;
      sseg <= SEG_BLANK;
    end else begin
      an   <= ~(4'b0001 << dig_idx);
      sseg <= seg_sel;
    end
  end

endmodule
